// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one 16-bit read per fetch pulse over a
// variable-latency handshake, IR decode and a WAIT watchdog.
module instr_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_fetch_pulse,
  input  logic [ADDR_W-1:0] pc,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [15:0]       ir,
  output logic [3:0]        opcode,
  output logic [1:0]        rd,
  output logic [1:0]        rs,
  output logic [7:0]        imm,
  output logic              en1,
  output logic              busy,
  output logic              fetch_err,
  output logic              fetch_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nx;
  logic [7:0]        wait_cnt;
  logic [7:0]        cnt_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [15:0]       ir_nx;
  logic              en1_nx;
  logic              err_nx;
  logic              ovr_nx;

  // Next-state, capture and watchdog decisions
  always_comb begin
    state_nx = state;
    cnt_nx   = wait_cnt;
    addr_nx  = mem_addr;
    ir_nx    = ir;
    en1_nx   = 1'b0;
    err_nx   = 1'b0;
    ovr_nx   = fetch_overrun;
    unique case (state)
      IDLE: begin
        if (en_fetch_pulse) begin
          addr_nx  = pc;
          state_nx = REQ;
        end
      end
      REQ: begin
        cnt_nx   = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          ir_nx    = mem_rdata;
          en1_nx   = 1'b1;
          state_nx = IDLE;
        end else if (wait_cnt == LAST) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else if (wait_cnt != 8'hFF) begin
          cnt_nx = wait_cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (en_fetch_pulse && (state != IDLE)) begin
      ovr_nx = 1'b1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      mem_addr      <= '0;
      ir            <= '0;
      mem_rd_req    <= 1'b0;
      busy          <= 1'b0;
      en1           <= 1'b0;
      fetch_err     <= 1'b0;
      fetch_overrun <= 1'b0;
    end else begin
      state         <= state_nx;
      wait_cnt      <= cnt_nx;
      mem_addr      <= addr_nx;
      ir            <= ir_nx;
      mem_rd_req    <= (state_nx == REQ);
      busy          <= (state_nx != IDLE);
      en1           <= en1_nx;
      fetch_err     <= err_nx;
      fetch_overrun <= ovr_nx;
    end
  end

  // IR field decode
  always_comb begin
    opcode = ir[15:12];
    rd     = ir[11:10];
    rs     = ir[9:8];
    imm    = ir[7:0];
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed corner cases plus random fetches
// against a transaction-level model with a queue-based scoreboard.
module tb_instr_fetch_unit;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_fetch_pulse = 1'b0;
  logic [7:0]  pc = '0;
  logic        mem_rd_req;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic [1:0]  rd;
  logic [1:0]  rs;
  logic [7:0]  imm;
  logic        en1;
  logic        busy;
  logic        fetch_err;
  logic        fetch_overrun;

  instr_fetch_unit #(.ADDR_W(8), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .en_fetch_pulse(en_fetch_pulse),
    .pc(pc),
    .mem_rd_req(mem_rd_req),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid),
    .ir(ir),
    .opcode(opcode),
    .rd(rd),
    .rs(rs),
    .imm(imm),
    .en1(en1),
    .busy(busy),
    .fetch_err(fetch_err),
    .fetch_overrun(fetch_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    int         cyc;
  } req_t;

  typedef struct {
    logic        ok;
    logic [15:0] ir;
    logic        ovr;
    int          cyc;
  } exp_t;

  req_t rq[$];
  exp_t oq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [15:0] m_ir = '0;
  bit m_ovr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, a, x, cyc);
    end
  endtask

  // Monitor: compare every request and every completion against queues
  always @(negedge clk) begin
    if (mon_en) begin
      req_t r;
      exp_t e;
      if (mem_rd_req) begin
        if (rq.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          r = rq.pop_front();
          chk("mem_addr", 32'(mem_addr), 32'(r.addr));
          chk("req_cycle", cyc, r.cyc);
        end
      end
      if (en1 && fetch_err) begin
        chk("en1_err_excl", 32'd1, 32'd0);
      end
      if (en1 || fetch_err) begin
        if (oq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = oq.pop_front();
          chk("en1", 32'(en1), 32'(e.ok));
          chk("fetch_err", 32'(fetch_err), 32'(!e.ok));
          chk("ir", 32'(ir), 32'(e.ir));
          chk("opcode", 32'(opcode), 32'(e.ir[15:12]));
          chk("rd", 32'(rd), 32'(e.ir[11:10]));
          chk("rs", 32'(rs), 32'(e.ir[9:8]));
          chk("imm", 32'(imm), 32'(e.ir[7:0]));
          chk("overrun", 32'(fetch_overrun), 32'(e.ovr));
          chk("done_cycle", cyc, e.cyc);
          chk("busy_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  // One fetch: pulse now, answer lat cycles after the request
  task automatic do_fetch(input logic [7:0] a, input logic [15:0] d,
                          input int lat, input bit ovr, input bit chain);
    int p;
    int k;
    exp_t e;
    en_fetch_pulse = 1'b1;
    pc = a;
    p = cyc;
    rq.push_back('{a, p + 1});
    if (ovr) m_ovr = 1'b1;
    if (lat <= TO) begin
      m_ir = d;
      e = '{1'b1, d, m_ovr, p + 2 + lat};
    end else begin
      e = '{1'b0, m_ir, m_ovr, p + 2 + TO};
    end
    oq.push_back(e);
    @(posedge clk); #1;
    en_fetch_pulse = 1'b0;
    pc = 8'($urandom);
    k = 0;
    while (!mem_rd_req && k < 4) begin
      @(posedge clk); #1;
      k++;
    end
    if (!mem_rd_req) begin
      chk("req_wait", 32'd0, 32'd1);
      return;
    end
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk); #1;
      en_fetch_pulse = ovr && (i == 1);
    end
    mem_rvalid = 1'b1;
    mem_rdata = d;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    en_fetch_pulse = 1'b0;
    mem_rdata = 16'($urandom);
    if (chain && lat <= TO) return;
    k = 0;
    while (busy && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) chk("idle_wait", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    en_fetch_pulse = 1'b1;
    pc = 8'h33;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_outs",
          {mem_rd_req, en1, busy, fetch_err, fetch_overrun},
          32'd0);
      chk("rst_ir", 32'(ir), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_fields", {opcode, rd, rs, imm}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    en_fetch_pulse = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    do_fetch(8'h05, 16'h7A3C, 2, 1'b0, 1'b0);
    do_fetch(8'h05, 16'h9101, 1, 1'b0, 1'b1);
    do_fetch(8'h06, 16'h1234, 3, 1'b0, 1'b0);
    do_fetch(8'h40, 16'hFFFF, 18, 1'b0, 1'b0);
    do_fetch(8'h41, 16'hBEEF, TO, 1'b0, 1'b0);
    do_fetch(8'h42, 16'hCAFE, TO + 1, 1'b0, 1'b0);
    do_fetch(8'h43, 16'h5A5A, 5, 1'b1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int lat;
      lat = int'($urandom_range(1, 20));
      do_fetch(8'($urandom), 16'($urandom), lat,
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end
    repeat (20) @(posedge clk);
    #1;
    chk("req_q_empty", rq.size(), 32'd0);
    chk("out_q_empty", oq.size(), 32'd0);

    mon_en = 1'b0;
    en_fetch_pulse = 1'b1;
    pc = 8'h77;
    @(posedge clk); #1;
    en_fetch_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ir", 32'(ir), 32'd0);
    chk("midrst_ovr", 32'(fetch_overrun), 32'd0);
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 16'hFFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_ir", 32'(ir), 32'd0);
      chk("late_en1", 32'(en1), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
